// File: rtl/icache_controller_if.sv
// Bundle of the CPU fetch, cache array and backing-memory signals seen by icache_controller.
// master = controller side, slave = CPU/cache/memory environment side.
interface icache_controller_if #(
    parameter int unsigned COUNT_W = 16
);
    logic                cpu_req;
    logic [31:0]         cpu_addr;
    logic [31:0]         cache_addr;
    logic                cache_hit;
    logic [31:0]         cache_instruction;
    logic [31:0]         instr_out;
    logic                instr_valid;
    logic                stall;
    logic                mem_req;
    logic [31:0]         mem_addr;
    logic                mem_ready;
    logic [127:0]        mem_data;
    logic                fill_en;
    logic [127:0]        fill_line;
    logic [COUNT_W-1:0]  hit_count;
    logic [COUNT_W-1:0]  miss_count;

    modport master (
        input  cpu_req, cpu_addr, cache_hit, cache_instruction, mem_ready, mem_data,
        output cache_addr, instr_out, instr_valid, stall, mem_req, mem_addr,
               fill_en, fill_line, hit_count, miss_count
    );

    modport slave (
        output cpu_req, cpu_addr, cache_hit, cache_instruction, mem_ready, mem_data,
        input  cache_addr, instr_out, instr_valid, stall, mem_req, mem_addr,
               fill_en, fill_line, hit_count, miss_count
    );
endinterface

// File: rtl/icache_controller.sv
// Instruction-cache controller: tag compare, line refill from backing memory and
// saturating hit/miss statistics.
module icache_controller #(
    parameter int unsigned COUNT_W = 16
) (
    input  logic                 clock,
    input  logic                 reset_n,
    icache_controller_if.master  bus
);
    typedef enum logic [1:0] {IDLE, COMPARE, MISS_REQ, FILL} state_t;

    localparam logic [COUNT_W-1:0] CNT_MAX = '1;

    state_t              state, state_next;
    logic [31:0]         addr_q;
    logic [127:0]        line_q;
    logic                refill_q;   // current lookup follows a fill, so it is not counted
    logic [COUNT_W-1:0]  hit_q, miss_q;

    logic                instr_valid_c, stall_c, mem_req_c, fill_en_c;
    logic [31:0]         instr_out_c;

    always_comb begin
        state_next    = state;
        instr_out_c   = '0;
        instr_valid_c = 1'b0;
        stall_c       = 1'b0;
        mem_req_c     = 1'b0;
        fill_en_c     = 1'b0;
        case (state)
            IDLE: begin
                if (bus.cpu_req) state_next = COMPARE;
            end
            COMPARE: begin
                if (bus.cache_hit) begin
                    instr_out_c   = bus.cache_instruction;
                    instr_valid_c = 1'b1;
                    state_next    = IDLE;
                end else begin
                    stall_c    = 1'b1;
                    state_next = MISS_REQ;
                end
            end
            MISS_REQ: begin
                stall_c   = 1'b1;
                mem_req_c = 1'b1;
                if (bus.mem_ready) state_next = FILL;
            end
            FILL: begin
                stall_c    = 1'b1;
                fill_en_c  = 1'b1;
                state_next = COMPARE;
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state    <= IDLE;
            addr_q   <= '0;
            line_q   <= '0;
            refill_q <= 1'b0;
            hit_q    <= '0;
            miss_q   <= '0;
        end else begin
            state <= state_next;
            if (state == IDLE && bus.cpu_req) begin
                addr_q   <= bus.cpu_addr;
                refill_q <= 1'b0;
            end
            if (state == MISS_REQ && bus.mem_ready) line_q <= bus.mem_data;
            if (state == FILL) refill_q <= 1'b1;
            if (state == COMPARE && !refill_q) begin
                if (bus.cache_hit && hit_q != CNT_MAX) hit_q <= hit_q + COUNT_W'(1);
                if (!bus.cache_hit && miss_q != CNT_MAX) miss_q <= miss_q + COUNT_W'(1);
            end
        end
    end

    assign bus.cache_addr  = addr_q;
    assign bus.mem_addr    = {addr_q[31:4], 4'b0000};
    assign bus.fill_line   = line_q;
    assign bus.instr_out   = instr_out_c;
    assign bus.instr_valid = instr_valid_c;
    assign bus.stall       = stall_c;
    assign bus.mem_req     = mem_req_c;
    assign bus.fill_en     = fill_en_c;
    assign bus.hit_count   = hit_q;
    assign bus.miss_count  = miss_q;
endmodule

// File: tb/tb_icache_controller.sv
// Bench for icache_controller: directed table, randomized transactions against a
// transaction-level model, counter saturation on a 4-bit shadow instance, and mid-miss reset.
module tb_icache_controller;
    logic clock = 1'b0;
    logic reset_n = 1'b0;
    always #5 clock = ~clock;

    icache_controller_if #(.COUNT_W(16)) bus ();
    icache_controller_if #(.COUNT_W(4))  bus4 ();

    // The 4-bit instance sees exactly the same inputs as the main one
    assign bus4.cpu_req           = bus.cpu_req;
    assign bus4.cpu_addr          = bus.cpu_addr;
    assign bus4.cache_hit         = bus.cache_hit;
    assign bus4.cache_instruction = bus.cache_instruction;
    assign bus4.mem_ready         = bus.mem_ready;
    assign bus4.mem_data          = bus.mem_data;

    icache_controller #(.COUNT_W(16)) dut  (.clock(clock), .reset_n(reset_n), .bus(bus));
    icache_controller #(.COUNT_W(4))  dut4 (.clock(clock), .reset_n(reset_n), .bus(bus4));

    typedef struct {
        logic [31:0]  addr;
        int unsigned  misses;     // fills needed before the cache hits (0..2)
        int unsigned  w0, w1;     // cycles of mem_req before mem_ready, per miss
        logic [31:0]  instr;
        logic [127:0] line;       // first fill line; second fill uses ~line
        int unsigned  exp_lat;
        logic [31:0]  exp_mem_addr;
    } vec_t;

    int checks = 0;
    int errors = 0;
    int unsigned hits = 0;
    int unsigned misses = 0;

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    function automatic int unsigned sat(input int unsigned v, input int unsigned maxv);
        return (v > maxv) ? maxv : v;
    endfunction

    task automatic check_counters();
        check("hit_count16",  bus.hit_count,   sat(hits, 65535));
        check("miss_count16", bus.miss_count,  sat(misses, 65535));
        check("hit_count4",   bus4.hit_count,  sat(hits, 15));
        check("miss_count4",  bus4.miss_count, sat(misses, 15));
    endtask

    // Entered and left just after a rising edge with the controller idle.
    task automatic run_txn(input vec_t v);
        int unsigned fills = 0;
        int unsigned waitc = 0;
        int unsigned memcyc = 0;
        int unsigned lat = 0;
        int unsigned w;
        int unsigned exp_memcyc;
        bit done = 1'b0;
        bus.cpu_req   = 1'b1;
        bus.cpu_addr  = v.addr;
        bus.cache_hit = 1'($urandom);
        bus.mem_ready = 1'($urandom);
        bus.mem_data  = {$urandom, $urandom, $urandom, $urandom};
        @(negedge clock);
        check("idle_stall", bus.stall, 0);
        @(posedge clock); #1;
        for (int cyc = 1; cyc <= 60 && !done; cyc++) begin
            bus.cpu_req   = 1'($urandom);
            bus.cpu_addr  = $urandom;
            bus.cache_hit = (fills == v.misses);
            bus.cache_instruction = bus.cache_hit ? v.instr : $urandom;
            w = (fills == 0) ? v.w0 : v.w1;
            if (bus.mem_req) begin
                bus.mem_ready = (waitc == w);
                bus.mem_data  = (fills == 0) ? v.line : ~v.line;
                if (waitc == w) waitc = 0; else waitc++;
            end else begin
                bus.mem_ready = 1'($urandom);
                bus.mem_data  = {$urandom, $urandom, $urandom, $urandom};
            end
            @(negedge clock);
            check("cache_addr", bus.cache_addr, v.addr);
            if (bus.mem_req) begin
                memcyc++;
                check("mem_addr", bus.mem_addr, v.exp_mem_addr);
            end
            if (bus.fill_en) begin
                check("fill_line", bus.fill_line, (fills == 0) ? v.line : ~v.line);
                fills++;
            end
            if (bus.instr_valid) begin
                lat  = cyc;
                done = 1'b1;
                check("instr_out", bus.instr_out, v.instr);
                check("hit_stall", bus.stall, 0);
            end else begin
                check("busy_stall", bus.stall, 1);
            end
            @(posedge clock); #1;
        end
        bus.cpu_req = 1'b0;
        if (!done) begin
            checks++;
            errors++;
            $display("FAIL timeout addr=%0h actual=no instr_valid required=instr_valid within 60 cycles", v.addr);
        end
        if (v.misses == 0) hits++; else misses++;
        exp_memcyc = (v.misses == 0) ? 0 : (v.w0 + 1) + ((v.misses > 1) ? v.w1 + 1 : 0);
        check("latency", lat, v.exp_lat);
        check("fill_count", fills, v.misses);
        check("mem_req_cycles", memcyc, exp_memcyc);
        check_counters();
        @(negedge clock);
        check("idle_valid", bus.instr_valid, 0);
        check("idle_mem_req", bus.mem_req, 0);
        @(posedge clock); #1;
    endtask

    function automatic vec_t rand_vec();
        vec_t v;
        v.addr   = $urandom;
        v.misses = $urandom_range(0, 2);
        v.w0     = $urandom_range(0, 3);
        v.w1     = $urandom_range(0, 3);
        v.instr  = $urandom;
        v.line   = {$urandom, $urandom, $urandom, $urandom};
        v.exp_lat = 1;
        if (v.misses > 0) v.exp_lat += v.w0 + 3;
        if (v.misses > 1) v.exp_lat += v.w1 + 3;
        v.exp_mem_addr = v.addr & 32'hFFFF_FFF0;
        return v;
    endfunction

    vec_t tbl[5];
    vec_t v;

    initial begin
        tbl[0] = '{32'h0000_0084, 0, 0, 0, 32'h8C08_0004, 128'h0, 1, 32'h0000_0080};
        tbl[1] = '{32'h0000_01AC, 1, 3, 0, 32'h0000_0013,
                   128'h0123456789ABCDEF0123456789ABCDEF, 7, 32'h0000_01A0};
        tbl[2] = '{32'h0000_0200, 1, 0, 0, 32'hDEAD_BEEF, 128'h1111_2222_3333_4444_5555_6666_7777_8888, 4, 32'h0000_0200};
        tbl[3] = '{32'h0000_03F4, 2, 1, 2, 32'hCAFE_F00D, 128'hA5A5_A5A5_0F0F_0F0F_3C3C_3C3C_9696_9696, 10, 32'h0000_03F0};
        tbl[4] = '{32'hFFFF_FFFF, 0, 0, 0, 32'h1234_5678, 128'h0, 1, 32'hFFFF_FFF0};

        bus.cpu_req = 1'b0;
        bus.cpu_addr = '0;
        bus.cache_hit = 1'b0;
        bus.cache_instruction = '0;
        bus.mem_ready = 1'b0;
        bus.mem_data = '0;

        #1;
        check("rst_cache_addr", bus.cache_addr, 0);
        check("rst_instr_valid", bus.instr_valid, 0);
        check("rst_stall", bus.stall, 0);
        check("rst_mem_req", bus.mem_req, 0);
        check("rst_fill_en", bus.fill_en, 0);
        check("rst_fill_line", bus.fill_line, 0);
        check_counters();
        @(posedge clock); @(negedge clock);
        reset_n = 1'b1;
        @(posedge clock); #1;

        for (int i = 0; i < 5; i++) run_txn(tbl[i]);

        // Seventeen hits in a row push the 4-bit counter into saturation
        for (int i = 0; i < 17; i++) begin
            v = rand_vec();
            v.misses = 0;
            v.exp_lat = 1;
            run_txn(v);
        end

        for (int i = 0; i < 40; i++) run_txn(rand_vec());

        // Reset in the middle of a miss: the line request is abandoned
        bus.cpu_req = 1'b1;
        bus.cpu_addr = 32'h0000_0500;
        bus.cache_hit = 1'b0;
        bus.mem_ready = 1'b0;
        @(posedge clock); #1;
        bus.cpu_req = 1'b0;
        @(posedge clock); #1;
        check("pre_rst_mem_req", bus.mem_req, 1);
        #2 reset_n = 1'b0;
        #1;
        hits = 0;
        misses = 0;
        check("async_mem_req", bus.mem_req, 0);
        check("async_stall", bus.stall, 0);
        check("async_fill_en", bus.fill_en, 0);
        check("async_cache_addr", bus.cache_addr, 0);
        check_counters();
        bus.mem_ready = 1'b1;
        bus.mem_data = {$urandom, $urandom, $urandom, $urandom};
        @(posedge clock); #1;
        reset_n = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(negedge clock);
            check("post_rst_fill_en", bus.fill_en, 0);
            check("post_rst_mem_req", bus.mem_req, 0);
            check("post_rst_fill_line", bus.fill_line, 0);
        end
        @(posedge clock); #1;
        bus.mem_ready = 1'b0;
        tbl[0] = '{32'h0000_0744, 1, 1, 0, 32'h0BAD_F00D, 128'hFEDC_BA98_7654_3210_FEDC_BA98_7654_3210, 5, 32'h0000_0740};
        run_txn(tbl[0]);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
